// File: rtl/axi_lite_bram_responder_pkg.sv
// Shared types and constants for the AXI4-Lite BRAM responder.
// Response codes and the read/write FSM state encodings live here.
package axi_lite_bram_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_DATA = 2'd2,
    R_RESP = 2'd3
  } read_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } write_state_t;

endpackage

// File: rtl/axi_lite_bram_responder_if.sv
// AXI4-Lite bus bundle between the processor-side master and the BRAM responder.
interface axi_lite_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_bram_responder_arbiter.sv
// Two-requester round-robin arbiter for the single BRAM port.
// The turn pointer only moves on contention, so lone requests never disturb fairness.
module bram_port_rr_arbiter (
  input  logic clk,
  input  logic resetn,
  input  logic i_rd_req,
  input  logic i_wr_req,
  output logic o_rd_gnt,
  output logic o_wr_gnt
);
  logic r_last_write;
  logic w_both;

  assign w_both   = i_rd_req & i_wr_req;
  assign o_wr_gnt = i_wr_req & (~i_rd_req | ~r_last_write);
  assign o_rd_gnt = i_rd_req & (~i_wr_req |  r_last_write);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_write <= 1'b0;
    end else if (w_both) begin
      r_last_write <= o_wr_gnt;
    end
  end
endmodule

// File: rtl/axi_lite_bram_responder.sv
// AXI4-Lite responder serving a single-port byte-enabled BRAM.
// Independent read and write FSMs share the BRAM port through a round-robin arbiter.
module axi_lite_bram_responder
  import axi_lite_bram_responder_pkg::*;
#(
  parameter int MEM_LINES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  axi_lite_if.slave                    s_axi,
  output logic [$clog2(MEM_LINES)-1:0] bram_addr,
  output logic                         bram_en,
  output logic [3:0]                   bram_be,
  output logic [31:0]                  bram_data_in,
  input  logic [31:0]                  bram_data_out
);
  localparam int IDX_W = $clog2(MEM_LINES);

  // Holds all readies low while reset is asserted and for the first edge after it.
  logic r_rst_done;

  read_state_t      r_rstate, w_rstate_nxt;
  logic [IDX_W-1:0] r_araddr, w_araddr_nxt;
  logic [31:0]      r_rdata,  w_rdata_nxt;
  logic [1:0]       r_rresp,  w_rresp_nxt;
  logic             w_arready, w_rvalid, w_rd_req, w_rd_gnt, w_ar_in_range;

  write_state_t     r_wstate, w_wstate_nxt;
  logic             r_aw_done, w_aw_done_nxt;
  logic             r_w_done,  w_w_done_nxt;
  logic [ADDR_W-3:0] r_awaddr, w_awaddr_nxt;
  logic [31:0]      r_wdata,  w_wdata_nxt;
  logic [3:0]       r_wstrb,  w_wstrb_nxt;
  logic [1:0]       r_bresp,  w_bresp_nxt;
  logic             w_awready, w_wready, w_bvalid, w_wr_req, w_wr_gnt;

  logic             w_unused;
  assign w_unused = ^{s_axi.araddr[1:0], s_axi.awaddr[1:0]};

  assign w_ar_in_range = (s_axi.araddr[ADDR_W-1:IDX_W+2] == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_araddr <= w_araddr_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rresp  <= w_rresp_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_araddr_nxt = r_araddr;
    w_rdata_nxt  = r_rdata;
    w_rresp_nxt  = r_rresp;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    w_rd_req     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = r_rst_done;
        if (w_arready && s_axi.arvalid) begin
          w_araddr_nxt = s_axi.araddr[IDX_W+1:2];
          if (w_ar_in_range) begin
            w_rstate_nxt = R_REQ;
          end else begin
            w_rresp_nxt  = RESP_DECERR;
            w_rdata_nxt  = '0;
            w_rstate_nxt = R_RESP;
          end
        end
      end
      R_REQ: begin
        w_rd_req = 1'b1;
        if (w_rd_gnt) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rdata_nxt  = bram_data_out;
        w_rresp_nxt  = RESP_OKAY;
        w_rstate_nxt = R_RESP;
      end
      R_RESP: begin
        w_rvalid = 1'b1;
        if (s_axi.rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // AW and W are captured independently; the range decision uses whichever
  // address is current, so a same-cycle AW+W pair moves on in one edge.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_awaddr_nxt  = r_awaddr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_bresp_nxt   = r_bresp;
    w_awready     = 1'b0;
    w_wready      = 1'b0;
    w_bvalid      = 1'b0;
    w_wr_req      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = r_rst_done & ~r_aw_done;
        w_wready  = r_rst_done & ~r_w_done;
        if (w_awready && s_axi.awvalid) begin
          w_aw_done_nxt = 1'b1;
          w_awaddr_nxt  = s_axi.awaddr[ADDR_W-1:2];
        end
        if (w_wready && s_axi.wvalid) begin
          w_w_done_nxt = 1'b1;
          w_wdata_nxt  = s_axi.wdata;
          w_wstrb_nxt  = s_axi.wstrb;
        end
        if (w_aw_done_nxt && w_w_done_nxt) begin
          if (w_awaddr_nxt[ADDR_W-3:IDX_W] == '0) begin
            w_wstate_nxt = W_REQ;
          end else begin
            w_bresp_nxt  = RESP_DECERR;
            w_wstate_nxt = W_RESP;
          end
        end
      end
      W_REQ: begin
        w_wr_req = 1'b1;
        if (w_wr_gnt) begin
          w_bresp_nxt  = RESP_OKAY;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.bready) begin
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  bram_port_rr_arbiter u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .i_rd_req (w_rd_req),
    .i_wr_req (w_wr_req),
    .o_rd_gnt (w_rd_gnt),
    .o_wr_gnt (w_wr_gnt)
  );

  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bresp   = r_bresp;

  assign bram_en      = w_rd_gnt | w_wr_gnt;
  assign bram_addr    = w_wr_gnt ? r_awaddr[IDX_W-1:0] : r_araddr;
  assign bram_be      = w_wr_gnt ? r_wstrb : 4'b0000;
  assign bram_data_in = w_wr_gnt ? r_wdata : 32'h0;
endmodule

// File: tb/tb_axi_lite_bram_responder.sv
// Directed bench for axi_lite_bram_responder with a behavioural byte-enabled BRAM.
module tb_axi_lite_bram_responder;
  localparam int MEM_LINES = 4096;
  localparam int ADDR_W    = 32;
  localparam int IDX_W     = 12;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [IDX_W-1:0] bram_addr;
  logic             bram_en;
  logic [3:0]       bram_be;
  logic [31:0]      bram_data_in;
  logic [31:0]      bram_data_out;

  int n_cmp = 0;
  int n_mis = 0;

  axi_lite_if #(.ADDR_W(ADDR_W)) axi ();

  axi_lite_bram_responder #(.MEM_LINES(MEM_LINES), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi         (axi),
    .bram_addr     (bram_addr),
    .bram_en       (bram_en),
    .bram_be       (bram_be),
    .bram_data_in  (bram_data_in),
    .bram_data_out (bram_data_out)
  );

  always #5 clk = ~clk;

  // BRAM model plus an access log (kind and cycle of every bram_en).
  logic [31:0] mem [MEM_LINES];
  int cyc = 0;
  int en_cnt = 0;
  int ev_n = 0;
  bit ev_wr [64];
  int ev_cyc [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_be[b]) mem[bram_addr][8*b +: 8] <= bram_data_in[8*b +: 8];
      end
      if (bram_be == 4'b0000) bram_data_out <= mem[bram_addr];
      if (ev_n < 64) begin
        ev_wr[ev_n]  <= (bram_be != 4'b0000);
        ev_cyc[ev_n] <= cyc;
      end
      ev_n   <= ev_n + 1;
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise the selected valids together and drop each after its handshake.
  task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [31:0] awa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] ara);
    bit ok = 1'b0;
    axi.awvalid = do_aw; axi.awaddr = awa;
    axi.wvalid  = do_w;  axi.wdata  = wd; axi.wstrb = ws;
    axi.arvalid = do_ar; axi.araddr = ara;
    for (int t = 0; t < 40; t++) begin
      bit haw, hw, har;
      haw = axi.awvalid & axi.awready;
      hw  = axi.wvalid  & axi.wready;
      har = axi.arvalid & axi.arready;
      @(negedge clk);
      if (haw) axi.awvalid = 1'b0;
      if (hw)  axi.wvalid  = 1'b0;
      if (har) axi.arvalid = 1'b0;
      if (!axi.awvalid && !axi.wvalid && !axi.arvalid) begin
        ok = 1'b1;
        break;
      end
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    chk("send_handshake", ok, 1);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit ok = 1'b0;
    resp = 2'bxx;
    axi.bready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (axi.bvalid) begin
        resp = axi.bresp;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    axi.bready = 1'b0;
    chk("b_handshake", ok, 1);
    $display("B  bresp=%0d  t=%0t", resp, $time);
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    bit ok = 1'b0;
    data = 'x; resp = 2'bxx;
    axi.rready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (axi.rvalid) begin
        data = axi.rdata;
        resp = axi.rresp;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    axi.rready = 1'b0;
    chk("r_handshake", ok, 1);
    $display("R  rdata=%h rresp=%0d  t=%0t", data, resp, $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rs, rs2;
    logic [31:0] rd;
    int          e0, v0;
    bit          seen;

    axi.awvalid = 0; axi.awaddr = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
    axi.bready = 0; axi.arvalid = 0; axi.araddr = 0; axi.rready = 0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_arready", axi.arready, 0);
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready",  axi.wready,  0);
    chk("rst_rvalid",  axi.rvalid,  0);
    chk("rst_bvalid",  axi.bvalid,  0);
    chk("rst_bram_en", bram_en,     0);
    chk("rst_rdata",   axi.rdata,   0);
    chk("rst_resp",    {axi.rresp, axi.bresp}, 0);

    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", axi.arready, 1);
    chk("post_rst_awready", axi.awready, 1);

    // AW+W in the same cycle, then read back
    e0 = en_cnt;
    send(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    wait_b(rs);
    chk("t1_bresp", rs, 2'b00);
    send(0, 0, 1, 0, 0, 0, 32'h10);
    wait_r(rd, rs);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_rresp", rs, 2'b00);
    chk("t1_en_count", en_cnt - e0, 2);

    // Partial strobe
    send(1, 1, 0, 32'h20, 32'hFFFFFFFF, 4'hF, 0);
    wait_b(rs);
    send(1, 1, 0, 32'h20, 32'h00001234, 4'h3, 0);
    wait_b(rs);
    chk("strb_bresp", rs, 2'b00);
    send(0, 0, 1, 0, 0, 0, 32'h20);
    wait_r(rd, rs);
    chk("strb_rdata", rd, 32'hFFFF1234);

    // W ahead of AW
    e0 = en_cnt;
    send(0, 1, 0, 0, 32'hA5A5A5A5, 4'hF, 0);
    chk("wfirst_wready_low",   axi.wready,  0);
    chk("wfirst_awready_high", axi.awready, 1);
    repeat (2) @(negedge clk);
    chk("wfirst_no_early_en",  en_cnt - e0, 0);
    chk("wfirst_no_early_b",   axi.bvalid,  0);
    send(1, 0, 0, 32'h30, 0, 0, 0);
    wait_b(rs);
    chk("wfirst_bresp", rs, 2'b00);
    chk("wfirst_single_b", axi.bvalid, 0);
    chk("wfirst_en_count", en_cnt - e0, 1);
    send(0, 0, 1, 0, 0, 0, 32'h30);
    wait_r(rd, rs);
    chk("wfirst_rdata", rd, 32'hA5A5A5A5);

    // Out of range and the last in-range word
    e0 = en_cnt;
    send(1, 1, 0, 32'h4000, 32'h12345678, 4'hF, 0);
    wait_b(rs);
    chk("oor_bresp", rs, 2'b11);
    send(0, 0, 1, 0, 0, 0, 32'h4000);
    wait_r(rd, rs);
    chk("oor_rresp", rs, 2'b11);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_no_en", en_cnt - e0, 0);
    send(1, 1, 0, 32'h3FFC, 32'h0BADCAFE, 4'hF, 0);
    wait_b(rs);
    chk("top_bresp", rs, 2'b00);
    send(0, 0, 1, 0, 0, 0, 32'h3FFF);
    wait_r(rd, rs);
    chk("top_rdata", rd, 32'h0BADCAFE);
    chk("top_rresp", rs, 2'b00);

    // Contention: first tie goes to the write, the next tie to the read
    v0 = ev_n;
    send(1, 1, 1, 32'h40, 32'h11112222, 4'hF, 32'h40);
    wait_b(rs);
    wait_r(rd, rs2);
    chk("arb1_first_is_wr",  ev_wr[v0],     1);
    chk("arb1_second_is_rd", ev_wr[v0 + 1], 0);
    chk("arb1_back_to_back", ev_cyc[v0 + 1] - ev_cyc[v0], 1);
    chk("arb1_rdata_new",    rd, 32'h11112222);
    v0 = ev_n;
    send(1, 1, 1, 32'h40, 32'h33334444, 4'hF, 32'h40);
    wait_b(rs);
    wait_r(rd, rs2);
    chk("arb2_first_is_rd",  ev_wr[v0],     0);
    chk("arb2_second_is_wr", ev_wr[v0 + 1], 1);
    chk("arb2_rdata_old",    rd, 32'h11112222);
    send(0, 0, 1, 0, 0, 0, 32'h40);
    wait_r(rd, rs);
    chk("arb2_readback", rd, 32'h33334444);

    // Backpressure on both response channels
    send(1, 1, 0, 32'h50, 32'hCAFEF00D, 4'hF, 0);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (axi.bvalid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_bvalid_seen", seen, 1);
    send(0, 0, 1, 0, 0, 0, 32'h50);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (axi.rvalid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_rvalid_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valids",  {axi.bvalid, axi.rvalid}, 2'b11);
      chk("bp_hold_rdata",   axi.rdata, 32'hCAFEF00D);
      chk("bp_hold_resps",   {axi.bresp, axi.rresp}, 4'b0000);
      chk("bp_hold_readies", {axi.arready, axi.awready}, 2'b00);
      @(negedge clk);
    end
    wait_b(rs);
    wait_r(rd, rs2);
    chk("bp_rdata", rd, 32'hCAFEF00D);
    chk("bp_readies_back", {axi.arready, axi.awready}, 2'b11);

    // Reset while the read sits in R_DATA
    e0 = en_cnt;
    send(0, 0, 1, 0, 0, 0, 32'h10);
    @(negedge clk);
    chk("rstmid_grant_done", en_cnt - e0, 1);
    resetn = 1'b0;
    #1;
    chk("rstmid_rvalid",  axi.rvalid,  0);
    chk("rstmid_arready", axi.arready, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rstmid_arready_back", axi.arready, 1);
    chk("rstmid_no_stale_r",   axi.rvalid,  0);
    send(0, 0, 1, 0, 0, 0, 32'h10);
    wait_r(rd, rs);
    chk("rstmid_rdata", rd, 32'hDEADBEEF);
    chk("rstmid_rresp", rs, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
